// File: rtl/cvxif_act_unit.sv
// ----------------------------------------------------------------------------
// cvxif_act_unit
//
// CV-X-IF style coprocessor unit that applies per-lane activation functions
// to a packed SIMD operand and returns results through a small in-order FIFO.
//
// Supported instructions (opcode 7'b0101011, funct3 in instr[14:12]):
//   000 ReLU  : max(x, 0)
//   001 LEAKY : x >= 0 ? x : x >>> s, s = rs2[log2(LANE_W)-1:0] (all lanes)
//   010 CLAMP : min(max(x, 0), max(b, 0)), b = same lane of rs2
//
// Optional feature macro:
//   CVXIF_ACT_CLAMP_EN - when defined, CLAMP is decoded and implemented.
//                        When undefined, funct3=010 is rejected and no clamp
//                        datapath exists.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   issue_valid_i        issue request valid
//   issue_ready_o        FIFO has room (registered count only)
//   issue_instr_i        instruction word
//   issue_id_i           instruction ID
//   issue_rs1_i/rs2_i    source operands
//   issue_accept_o       instruction decodes as supported (combinational)
//   issue_writeback_o    instruction writes rd (same as accept)
//   flush_i              drop all pending results
//   result_valid_o       FIFO head valid
//   result_ready_i       consumer takes FIFO head
//   result_id_o/rd_o     ID and destination register of FIFO head
//   result_data_o        result data of FIFO head
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Issue additionally requires the instruction to be supported.
// Result outputs hold steady while valid=1 and ready=0.
// ----------------------------------------------------------------------------
module cvxif_act_unit #(
    parameter int XLEN       = 32,
    parameter int LANE_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            issue_valid_i,
    output logic            issue_ready_o,
    input  logic [31:0]     issue_instr_i,
    input  logic [ID_W-1:0] issue_id_i,
    input  logic [XLEN-1:0] issue_rs1_i,
    input  logic [XLEN-1:0] issue_rs2_i,
    output logic            issue_accept_o,
    output logic            issue_writeback_o,
    input  logic            flush_i,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic [ID_W-1:0] result_id_o,
    output logic [4:0]      result_rd_o,
    output logic [XLEN-1:0] result_data_o
);

    localparam int LANES = XLEN / LANE_W;
    localparam int SH_W  = $clog2(LANE_W);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       supported;

    assign opcode = issue_instr_i[6:0];
    assign funct3 = issue_instr_i[14:12];

    always_comb begin
        supported = 1'b0;
        if (opcode == 7'b0101011) begin
            case (funct3)
                3'b000:  supported = 1'b1;
                3'b001:  supported = 1'b1;
`ifdef CVXIF_ACT_CLAMP_EN
                3'b010:  supported = 1'b1;
`endif
                default: supported = 1'b0;
            endcase
        end
    end

    assign issue_accept_o    = supported;
    assign issue_writeback_o = supported;

    // ------------------------------------------------------------------
    // Lane datapath (purely combinational, evaluated in the issue cycle)
    // ------------------------------------------------------------------
    logic [SH_W-1:0] shamt;
    logic [XLEN-1:0] alu_res;

    assign shamt = issue_rs2_i[SH_W-1:0];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [LANE_W-1:0] x;
        logic signed [LANE_W-1:0] relu_v;
        logic signed [LANE_W-1:0] leaky_v;
        logic signed [LANE_W-1:0] lane_res;

        assign x       = issue_rs1_i[g*LANE_W +: LANE_W];
        assign relu_v  = x[LANE_W-1] ? '0 : x;
        // Arithmetic shift floors toward minus infinity for negative x.
        assign leaky_v = x[LANE_W-1] ? (x >>> shamt) : x;

`ifdef CVXIF_ACT_CLAMP_EN
        logic signed [LANE_W-1:0] b;
        logic signed [LANE_W-1:0] bpos;
        logic signed [LANE_W-1:0] clamp_v;

        assign b       = issue_rs2_i[g*LANE_W +: LANE_W];
        assign bpos    = b[LANE_W-1] ? '0 : b;
        // Both operands are non-negative here, so the compare is safe.
        assign clamp_v = (relu_v > bpos) ? bpos : relu_v;
`endif

        always_comb begin
            lane_res = relu_v;
            case (funct3)
                3'b001:  lane_res = leaky_v;
`ifdef CVXIF_ACT_CLAMP_EN
                3'b010:  lane_res = clamp_v;
`endif
                default: lane_res = relu_v;
            endcase
        end

        assign alu_res[g*LANE_W +: LANE_W] = lane_res;
    end

    // Bits of the inputs the datapath never looks at.
`ifdef CVXIF_ACT_CLAMP_EN
    logic unused_bits;
    assign unused_bits = ^issue_instr_i[31:15];
`else
    logic unused_bits;
    assign unused_bits = ^{issue_instr_i[31:15], issue_rs2_i[XLEN-1:SH_W]};
`endif

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [ID_W-1:0]  mem_id   [FIFO_DEPTH];
    logic [4:0]       mem_rd   [FIFO_DEPTH];
    logic [XLEN-1:0]  mem_data [FIFO_DEPTH];

    logic push;
    logic pop;

    // Ready depends only on the registered count, so a full FIFO refuses
    // issue even if the head is popped in the same cycle.
    assign issue_ready_o  = (count_q != DEPTH_C);
    assign result_valid_o = (count_q != '0);

    assign push = issue_valid_i & issue_ready_o & supported;
    assign pop  = result_valid_o & result_ready_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the outputs are masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            mem_id[wptr_q]   <= issue_id_i;
            mem_rd[wptr_q]   <= issue_instr_i[11:7];
            mem_data[wptr_q] <= alu_res;
        end
    end

    assign result_id_o   = result_valid_o ? mem_id[rptr_q]   : '0;
    assign result_rd_o   = result_valid_o ? mem_rd[rptr_q]   : '0;
    assign result_data_o = result_valid_o ? mem_data[rptr_q] : '0;

endmodule

// File: tb/tb_cvxif_act_unit.sv
// ----------------------------------------------------------------------------
// tb_cvxif_act_unit
//
// Self-checking bench for cvxif_act_unit (XLEN=32, LANE_W=8, FIFO_DEPTH=4).
// Inputs change on the falling edge and outputs are sampled 1 ns later, well
// away from the rising edge. A queue-based reference model tracks the FIFO
// contents; lane results are computed with integer arithmetic.
// ----------------------------------------------------------------------------
module tb_cvxif_act_unit;

    localparam int XLEN   = 32;
    localparam int LANE_W = 8;
    localparam int DEPTH  = 4;
    localparam int ID_W   = 3;
    localparam int ENT_W  = ID_W + 5 + XLEN;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    logic            issue_valid_i;
    logic            issue_ready_o;
    logic [31:0]     issue_instr_i;
    logic [ID_W-1:0] issue_id_i;
    logic [XLEN-1:0] issue_rs1_i;
    logic [XLEN-1:0] issue_rs2_i;
    logic            issue_accept_o;
    logic            issue_writeback_o;
    logic            flush_i;
    logic            result_valid_o;
    logic            result_ready_i;
    logic [ID_W-1:0] result_id_o;
    logic [4:0]      result_rd_o;
    logic [XLEN-1:0] result_data_o;

    cvxif_act_unit #(
        .XLEN(XLEN), .LANE_W(LANE_W), .FIFO_DEPTH(DEPTH), .ID_W(ID_W)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .issue_valid_i    (issue_valid_i),
        .issue_ready_o    (issue_ready_o),
        .issue_instr_i    (issue_instr_i),
        .issue_id_i       (issue_id_i),
        .issue_rs1_i      (issue_rs1_i),
        .issue_rs2_i      (issue_rs2_i),
        .issue_accept_o   (issue_accept_o),
        .issue_writeback_o(issue_writeback_o),
        .flush_i          (flush_i),
        .result_valid_o   (result_valid_o),
        .result_ready_i   (result_ready_i),
        .result_id_o      (result_id_o),
        .result_rd_o      (result_rd_o),
        .result_data_o    (result_data_o)
    );

    // ---------------- scoreboard ----------------
    logic [ENT_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd);
        return {17'h0, f3, rd, 7'b0101011};
    endfunction

    function automatic bit ref_supported(input logic [31:0] instr);
        if (instr[6:0] != 7'b0101011) return 0;
        if (instr[14:12] == 3'd0 || instr[14:12] == 3'd1) return 1;
`ifdef CVXIF_ACT_CLAMP_EN
        if (instr[14:12] == 3'd2) return 1;
`endif
        return 0;
    endfunction

    function automatic longint to_signed(input longint u);
        if (u >= (longint'(1) << (LANE_W - 1))) return u - (longint'(1) << LANE_W);
        return u;
    endfunction

    function automatic logic [XLEN-1:0] ref_result(input logic [2:0] f3,
                                                   input logic [XLEN-1:0] rs1,
                                                   input logic [XLEN-1:0] rs2);
        logic [XLEN-1:0] r = '0;
        longint mask = (longint'(1) << LANE_W) - 1;
        longint s = longint'(rs2) % LANE_W;
        longint p = longint'(1) << s;
        for (int l = 0; l < XLEN / LANE_W; l++) begin
            longint x = to_signed((longint'(rs1) >> (l * LANE_W)) & mask);
            longint b = to_signed((longint'(rs2) >> (l * LANE_W)) & mask);
            longint y;
            longint xp = (x < 0) ? 0 : x;
            longint bp = (b < 0) ? 0 : b;
            if (f3 == 3'd1)
                // floor(x / 2^s) for negative x using truncating division
                y = (x >= 0) ? x : (x - (p - 1)) / p;
            else if (f3 == 3'd2)
                y = (xp < bp) ? xp : bp;
            else
                y = xp;
            r = r | (XLEN'(y & mask) << (l * LANE_W));
        end
        return r;
    endfunction

    // ---------------- driver ----------------
    // One clock cycle: apply inputs, check all outputs against the model,
    // then advance the model at the rising edge. Returns whether an issue
    // handshake took place.
    task automatic cycle(input logic v, input logic [31:0] instr, input logic [ID_W-1:0] id,
                         input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                         input logic rr, input logic fl, output bit hs);
        logic [ENT_W-1:0] head;
        bit pop;
        issue_valid_i  = v;
        issue_instr_i  = instr;
        issue_id_i     = id;
        issue_rs1_i    = rs1;
        issue_rs2_i    = rs2;
        result_ready_i = rr;
        flush_i        = fl;
        #1;
        check("issue_ready", issue_ready_o, exp_q.size() < DEPTH);
        check("accept", issue_accept_o, ref_supported(instr));
        check("writeback", issue_writeback_o, ref_supported(instr));
        check("result_valid", result_valid_o, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            check("result_id", result_id_o, head[ENT_W-1 -: ID_W]);
            check("result_rd", result_rd_o, head[XLEN +: 5]);
            check("result_data", result_data_o, head[XLEN-1:0]);
        end
        hs  = v && (exp_q.size() < DEPTH) && ref_supported(instr);
        pop = (exp_q.size() != 0) && rr;
        @(posedge clk_i);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (hs) exp_q.push_back({id, instr[11:7], ref_result(instr[14:12], rs1, rs2)});
        end
        @(negedge clk_i);
    endtask

    task automatic idle(input logic rr);
        bit hs;
        cycle(1'b0, 32'h0, '0, '0, '0, rr, 1'b0, hs);
    endtask

    task automatic do_reset();
        issue_valid_i = 1'b0;
        flush_i       = 1'b0;
        issue_instr_i = 32'h0;
        rst_ni        = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        exp_q.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("rst_valid", result_valid_o, 1'b0);
        check("rst_id", result_id_o, '0);
        check("rst_rd", result_rd_o, '0);
        check("rst_data", result_data_o, '0);
        check("rst_ready", issue_ready_o, 1'b1);
        check("rst_accept", issue_accept_o, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit hs;
        bit done;
        issue_valid_i  = 1'b0;
        issue_instr_i  = 32'h0;
        issue_id_i     = '0;
        issue_rs1_i    = '0;
        issue_rs2_i    = '0;
        result_ready_i = 1'b0;
        flush_i        = 1'b0;
        rst_ni         = 1'b0;
        @(negedge clk_i);
        do_reset();

        // ReLU with result one cycle after the handshake
        cycle(1'b1, mk_instr(3'd0, 5'd9), 3'd5, 32'h807FFF01, 32'h0, 1'b0, 1'b0, hs);
        #1;
        check("relu_valid_t1", result_valid_o, 1'b1);
        check("relu_data", result_data_o, 32'h007F0001);
        check("relu_id", result_id_o, 3'd5);
        check("relu_rd", result_rd_o, 5'd9);
        idle(1'b1);

        // LEAKY
        cycle(1'b1, mk_instr(3'd1, 5'd3), 3'd1, 32'hF0811000, 32'h00000002, 1'b0, 1'b0, hs);
        #1;
        check("leaky_data", result_data_o, 32'hFCE01000);
        idle(1'b1);

        // CLAMP (rejected when the feature is compiled out)
        cycle(1'b1, mk_instr(3'd2, 5'd4), 3'd2, 32'h7F209005, 32'h10101080, 1'b0, 1'b0, hs);
        #1;
`ifdef CVXIF_ACT_CLAMP_EN
        check("clamp_data", result_data_o, 32'h10100000);
`else
        check("clamp_rejected", result_valid_o, 1'b0);
`endif
        idle(1'b1);

        // Backpressure: IDs 0..3 fill the FIFO, ID 4 waits
        for (int i = 0; i < 5; i++)
            cycle(1'b1, mk_instr(3'd0, 5'(i)), ID_W'(i), $urandom, '0, 1'b0, 1'b0, hs);
        check("bp_full_ready", issue_ready_o, 1'b0);
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            cycle(1'b1, mk_instr(3'd0, 5'd4), 3'd4, $urandom, '0, 1'b1, 1'b0, hs);
            if (hs) done = 1;
        end
        check("bp_id4_accepted", done, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Flush with 3 pending and a simultaneous issue
        for (int i = 0; i < 3; i++)
            cycle(1'b1, mk_instr(3'd1, 5'd7), ID_W'(i), $urandom, $urandom, 1'b0, 1'b0, hs);
        cycle(1'b1, mk_instr(3'd0, 5'd7), 3'd6, $urandom, '0, 1'b1, 1'b1, hs);
        #1;
        check("flush_valid", result_valid_o, 1'b0);
        check("flush_ready", issue_ready_o, 1'b1);

        // Reject funct3=111: no FIFO write
        cycle(1'b1, mk_instr(3'd7, 5'd1), 3'd1, $urandom, '0, 1'b0, 1'b0, hs);
        #1;
        check("reject_no_write", result_valid_o, 1'b0);

        // Reset with 2 pending while the consumer is ready
        for (int i = 0; i < 2; i++)
            cycle(1'b1, mk_instr(3'd0, 5'd2), ID_W'(i), $urandom, '0, 1'b0, 1'b0, hs);
        result_ready_i = 1'b1;
        do_reset();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] instr;
            instr = $urandom;
            if ($urandom_range(0, 9) < 8) begin
                instr[6:0]   = 7'b0101011;
                instr[14:12] = 3'($urandom_range(0, 3));
            end
            cycle(1'($urandom_range(0, 3) != 0), instr, ID_W'($urandom), $urandom, $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0), hs);
        end
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
